// File: rtl/cv32e40p_apu_share.sv
// Shares one clock-gated APU/FPU among NUM_CORES cores.
// Handles round-robin arbitration, in-order result return and the FPU clock gate.
//
// Ports:
//   clk_i, rst_i           clock and asynchronous active-high reset
//   core_req_i/gnt_o       per-core request and grant (grant one-hot or zero)
//   core_operands_i/op_i/flags_i   per-core request payload
//   core_rvalid_o          per-core result valid (one-hot or zero)
//   core_result_o/rflags_o result and flags, broadcast to every core
//   apu_req_o/gnt_i        FPU request handshake
//   apu_operands_o/op_o/flags_o    payload of the current winner
//   apu_rvalid_i/result_i/rflags_i FPU response, in issue order
//   apu_clk_en_o           FPU clock-gate enable
//   busy_o                 operations are in flight
//   err_o                  sticky: a response arrived with nothing in flight
//   stat_grant_o           per-core grant counters
//
// Build option: define CV32E40P_APU_SHARE_STATS_EN to build saturating
// 32-bit grant counters. Without it stat_grant_o is tied to zero.

module cv32e40p_apu_share #(
  parameter int unsigned NUM_CORES       = 2,
  parameter int unsigned NARGS           = 3,
  parameter int unsigned WOP             = 6,
  parameter int unsigned NDSFLAGS        = 15,
  parameter int unsigned NUSFLAGS        = 5,
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned CG_HOLD         = 2
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  logic [NUM_CORES-1:0]                  core_req_i,
  output logic [NUM_CORES-1:0]                  core_gnt_o,
  input  logic [NUM_CORES-1:0][NARGS-1:0][31:0] core_operands_i,
  input  logic [NUM_CORES-1:0][WOP-1:0]         core_op_i,
  input  logic [NUM_CORES-1:0][NDSFLAGS-1:0]    core_flags_i,
  output logic [NUM_CORES-1:0]                  core_rvalid_o,
  output logic [NUM_CORES-1:0][31:0]           core_result_o,
  output logic [NUM_CORES-1:0][NUSFLAGS-1:0]    core_rflags_o,
  output logic                                  apu_req_o,
  input  logic                                  apu_gnt_i,
  output logic [NARGS-1:0][31:0]                apu_operands_o,
  output logic [WOP-1:0]                        apu_op_o,
  output logic [NDSFLAGS-1:0]                   apu_flags_o,
  input  logic                                  apu_rvalid_i,
  input  logic [31:0]                           apu_result_i,
  input  logic [NUSFLAGS-1:0]                   apu_rflags_i,
  output logic                                  apu_clk_en_o,
  output logic                                  busy_o,
  output logic                                  err_o,
  output logic [NUM_CORES-1:0][31:0]            stat_grant_o
);

  localparam int unsigned IW = $clog2(NUM_CORES);
  localparam int unsigned PW =
    (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1);

  localparam logic [IW-1:0] LAST_CORE = IW'(NUM_CORES - 1);
  localparam logic [PW-1:0] LAST_SLOT = PW'(MAX_OUTSTANDING - 1);
  localparam logic [CW-1:0] FULL_CNT  = CW'(MAX_OUTSTANDING);
  localparam logic [3:0]    HOLD_INIT = 4'(CG_HOLD);

  logic [IW-1:0] rr_q;
  logic [IW-1:0] win;
  logic [IW-1:0] cand;
  logic          found;

  logic [IW-1:0] fifo_q [MAX_OUTSTANDING];
  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] rd_ptr_q;
  logic [CW-1:0] cnt_q;
  logic [3:0]    hold_q;
  logic          err_q;

  logic any_req;
  logic full;
  logic empty;
  logic fire;
  logic pop;
  logic [IW-1:0] head;

  // Scan from rr_q upward, wrapping, for the first requester.
  always_comb begin
    win   = rr_q;
    cand  = rr_q;
    found = 1'b0;
    for (int unsigned k = 0; k < NUM_CORES; k++) begin
      cand = IW'((32'(rr_q) + k) % NUM_CORES);
      if (!found && core_req_i[cand]) begin
        win   = cand;
        found = 1'b1;
      end
    end
  end

  assign any_req = |core_req_i;
  assign full    = (cnt_q == FULL_CNT);
  assign empty   = (cnt_q == '0);

  // Full blocks the grant even when a pop frees a slot this cycle,
  // keeping the request path independent of the response path.
  assign apu_req_o = any_req && !full;
  assign fire      = apu_req_o && apu_gnt_i;
  assign pop       = apu_rvalid_i && !empty;
  assign head      = fifo_q[rd_ptr_q];

  assign apu_operands_o = core_operands_i[win];
  assign apu_op_o       = core_op_i[win];
  assign apu_flags_o    = core_flags_i[win];

  always_comb begin
    core_gnt_o = '0;
    if (fire) core_gnt_o[win] = 1'b1;
  end

  always_comb begin
    core_rvalid_o = '0;
    if (pop) core_rvalid_o[head] = 1'b1;
  end

  for (genvar i = 0; i < NUM_CORES; i++) begin : g_bcast
    assign core_result_o[i] = apu_result_i;
    assign core_rflags_o[i] = apu_rflags_i;
  end

  assign busy_o       = !empty;
  assign err_o        = err_q;
  assign apu_clk_en_o = any_req || busy_o || (hold_q != '0);

  // Tag storage needs no reset: entries are only read while counted.
  always_ff @(posedge clk_i) begin
    if (fire) fifo_q[wr_ptr_q] <= win;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_q     <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      hold_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      if (fire) begin
        wr_ptr_q <= (wr_ptr_q == LAST_SLOT) ? '0 : wr_ptr_q + PW'(1);
        rr_q     <= (win == LAST_CORE) ? '0 : win + IW'(1);
      end
      if (pop) begin
        rd_ptr_q <= (rd_ptr_q == LAST_SLOT) ? '0 : rd_ptr_q + PW'(1);
      end
      if (fire && !pop) cnt_q <= cnt_q + CW'(1);
      else if (!fire && pop) cnt_q <= cnt_q - CW'(1);
      if (apu_rvalid_i && empty) err_q <= 1'b1;
      if (any_req || busy_o) hold_q <= HOLD_INIT;
      else if (hold_q != '0) hold_q <= hold_q - 4'd1;
    end
  end

`ifdef CV32E40P_APU_SHARE_STATS_EN
  logic [NUM_CORES-1:0][31:0] stat_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stat_q <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_CORES; i++) begin
        if (core_gnt_o[i] && (stat_q[i] != 32'hFFFF_FFFF))
          stat_q[i] <= stat_q[i] + 32'd1;
      end
    end
  end

  assign stat_grant_o = stat_q;
`else
  assign stat_grant_o = '0;
`endif

endmodule
